// File: rtl/onecycle_core_p_if.sv
// Host-side bundle for onecycle_core_p: program-load port, register debug port and status.
// The host drives the master side; the core implements the slave side.
interface onecycle_core_p_if #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int RB = 2
);
  localparam int IW = 6 + RB + ((DW > AW) ? DW : AW);

  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic [RB-1:0] dbg_sel;
  logic [DW-1:0] dbg_data;
  logic [AW-1:0] pc;
  logic          halted;
  logic          stack_err;

  modport master (
    output load_en, load_addr, load_data, dbg_sel,
    input  dbg_data, pc, halted, stack_err
  );

  modport slave (
    input  load_en, load_addr, load_data, dbg_sel,
    output dbg_data, pc, halted, stack_err
  );
endinterface

// File: rtl/onecycle_core_p.sv
// Parametrised single-cycle core: combinational fetch/decode/execute, every piece of
// architectural state commits on one rising edge. Host loads imem while load_en is high.
module onecycle_core_p #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int RB = 2,
  parameter int SD = 4
) (
  input  logic              clk,
  input  logic              reset,
  onecycle_core_p_if.slave  bus
);
  localparam int IW  = 6 + RB + ((DW > AW) ? DW : AW);
  localparam int NR  = 2 ** RB;
  localparam int SPW = $clog2(SD + 1);
  localparam int SIW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00, OP_MOV  = 5'h01, OP_ADD  = 5'h02, OP_SUB  = 5'h03,
    OP_AND  = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_NOT  = 5'h07,
    OP_ADDI = 5'h08, OP_SUBI = 5'h09, OP_CMP  = 5'h0A, OP_LD   = 5'h0B,
    OP_ST   = 5'h0C, OP_LDI  = 5'h0D, OP_JMP  = 5'h10, OP_JZ   = 5'h11,
    OP_JNZ  = 5'h12, OP_JL   = 5'h13, OP_JG   = 5'h14, OP_CALL = 5'h15,
    OP_RET  = 5'h16, OP_HALT = 5'h1F
  } opcode_t;

  logic [IW-1:0]  imem [2**AW];
  logic [DW-1:0]  dmem [2**DW];
  logic [DW-1:0]  regs [NR];
  logic [AW-1:0]  stack_mem [2**SIW];

  logic [AW-1:0]  pc_reg, pc_next, pc_inc;
  logic [SPW-1:0] sp_reg;
  logic           z_reg, c_reg, z_next, c_next;
  logic           halted_reg, halted_next, stack_err_reg;

  opcode_t        op;
  logic [RB-1:0]  rd, rs;
  logic [DW-1:0]  imm, a, b, wdata;
  logic [AW-1:0]  target, ret_addr;
  logic [DW:0]    res_ext;
  logic           exec, reg_we, flag_we, dmem_we, push, pop, err, taken, is_seq;
  logic [NR-1:0]  reg_wen;

  assign op       = opcode_t'(imem[pc_reg][IW-1 -: 5]);
  assign rd       = imem[pc_reg][IW-6 -: RB];
  assign rs       = imem[pc_reg][IW-6-RB -: RB];
  assign imm      = imem[pc_reg][IW-6-RB -: DW];
  assign target   = imem[pc_reg][IW-6 -: AW];
  assign a        = regs[rd];
  assign b        = regs[rs];
  assign pc_inc   = pc_reg + AW'(1);
  assign ret_addr = stack_mem[SIW'(sp_reg - SPW'(1))];
  assign exec     = !reset && !bus.load_en && !halted_reg;

  always_comb begin
    res_ext     = '0;
    wdata       = '0;
    reg_we      = 1'b0;
    flag_we     = 1'b0;
    dmem_we     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    err         = 1'b0;
    taken       = 1'b0;
    is_seq      = 1'b1;
    halted_next = 1'b0;
    pc_next     = pc_inc;
    case (op)
      OP_MOV:  begin wdata = b; reg_we = 1'b1; end
      OP_ADD:  begin res_ext = {1'b0, a} + {1'b0, b};   reg_we = 1'b1; flag_we = 1'b1; end
      OP_SUB:  begin res_ext = {1'b0, a} - {1'b0, b};   reg_we = 1'b1; flag_we = 1'b1; end
      OP_AND:  begin res_ext = {1'b0, a & b};           reg_we = 1'b1; flag_we = 1'b1; end
      OP_OR:   begin res_ext = {1'b0, a | b};           reg_we = 1'b1; flag_we = 1'b1; end
      OP_XOR:  begin res_ext = {1'b0, a ^ b};           reg_we = 1'b1; flag_we = 1'b1; end
      OP_NOT:  begin res_ext = {1'b0, ~b};              reg_we = 1'b1; flag_we = 1'b1; end
      OP_ADDI: begin res_ext = {1'b0, a} + {1'b0, imm}; reg_we = 1'b1; flag_we = 1'b1; end
      OP_SUBI: begin res_ext = {1'b0, a} - {1'b0, imm}; reg_we = 1'b1; flag_we = 1'b1; end
      OP_CMP:  begin res_ext = {1'b0, a} - {1'b0, b};   flag_we = 1'b1; end
      OP_LD:   begin wdata = dmem[b]; reg_we = 1'b1; end
      OP_ST:   dmem_we = 1'b1;
      OP_LDI:  begin wdata = imm; reg_we = 1'b1; end
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = z_reg;
      OP_JNZ:  taken = !z_reg;
      OP_JL:   taken = c_reg;
      OP_JG:   taken = !c_reg && !z_reg;
      OP_CALL: begin
        is_seq = 1'b0;
        if (sp_reg == SPW'(SD)) begin
          err = 1'b1; halted_next = 1'b1; pc_next = pc_reg;
        end else begin
          push = 1'b1; pc_next = target;
        end
      end
      OP_RET: begin
        is_seq = 1'b0;
        if (sp_reg == '0) begin
          err = 1'b1; halted_next = 1'b1; pc_next = pc_reg;
        end else begin
          pop = 1'b1; pc_next = ret_addr;
        end
      end
      OP_HALT: begin is_seq = 1'b0; halted_next = 1'b1; pc_next = pc_reg; end
      default: ;
    endcase
    if (flag_we && op != OP_CMP)
      wdata = res_ext[DW-1:0];
    if (taken) begin
      is_seq  = 1'b0;
      pc_next = target;
    end
    // Falling off the end of program memory stops the core instead of wrapping to 0.
    if (is_seq && pc_reg == '1) begin
      pc_next     = pc_reg;
      halted_next = 1'b1;
    end
    z_next = (res_ext[DW-1:0] == '0);
    c_next = res_ext[DW];
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_wen
    assign reg_wen[gi] = exec && reg_we && (rd == RB'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg        <= '0;
      sp_reg        <= '0;
      z_reg         <= 1'b0;
      c_reg         <= 1'b0;
      halted_reg    <= 1'b0;
      stack_err_reg <= 1'b0;
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (bus.load_en) begin
      pc_reg        <= '0;
      sp_reg        <= '0;
      halted_reg    <= 1'b0;
      stack_err_reg <= 1'b0;
    end else if (!halted_reg) begin
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
      if (err) stack_err_reg <= 1'b1;
      if (flag_we) begin
        z_reg <= z_next;
        c_reg <= c_next;
      end
      if (push) sp_reg <= sp_reg + SPW'(1);
      if (pop)  sp_reg <= sp_reg - SPW'(1);
      for (int i = 0; i < NR; i++)
        if (reg_wen[i]) regs[i] <= wdata;
    end
  end

  // Memories carry no reset: imem and dmem contents survive both reset and reload.
  always_ff @(posedge clk) begin
    if (!reset && bus.load_en) imem[bus.load_addr] <= bus.load_data;
    if (exec && dmem_we)       dmem[b] <= a;
    if (exec && push)          stack_mem[SIW'(sp_reg)] <= pc_inc;
  end

  assign bus.dbg_data  = regs[bus.dbg_sel];
  assign bus.pc        = pc_reg;
  assign bus.halted    = halted_reg;
  assign bus.stack_err = stack_err_reg;
endmodule

// File: tb/tb_onecycle_core_p.sv
// Scoreboard bench for onecycle_core_p: each program pushes its expected end state,
// which is popped and compared once the core stops (or after a fixed run).
module tb_onecycle_core_p;
  localparam int DW = 8, AW = 8, RB = 2, SD = 4, IW = 16;

  localparam logic [4:0] O_NOP = 5'h00, O_ADD = 5'h02, O_XOR = 5'h06, O_NOT = 5'h07,
    O_ADDI = 5'h08, O_SUBI = 5'h09, O_CMP = 5'h0A, O_LD = 5'h0B, O_ST = 5'h0C,
    O_LDI = 5'h0D, O_JMP = 5'h10, O_JZ = 5'h11, O_JNZ = 5'h12, O_JL = 5'h13,
    O_JG = 5'h14, O_CALL = 5'h15, O_RET = 5'h16, O_HALT = 5'h1F;

  localparam int S_PC = 4, S_HALT = 5, S_SERR = 6, S_CYC = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onecycle_core_p_if #(.DW(DW), .AW(AW), .RB(RB)) bus ();
  onecycle_core_p #(.DW(DW), .AW(AW), .RB(RB), .SD(SD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] prog[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            last_cycles = 0;

  function automatic logic [IW-1:0] rr(logic [4:0] op, int rd, int rs);
    return {op, 2'(rd), 2'(rs), 7'b0};
  endfunction
  function automatic logic [IW-1:0] ri(logic [4:0] op, int rd, int imm);
    return {op, 2'(rd), 8'(imm), 1'b0};
  endfunction
  function automatic logic [IW-1:0] jt(logic [4:0] op, int tgt);
    return {op, 8'(tgt), 3'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_val(input string tag, input int src, input int val);
    exp_t e;
    e.tag = tag; e.src = src; e.val = 32'(val);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.src)
        0, 1, 2, 3: begin
          bus.dbg_sel = RB'(e.src);
          #1;
          obs = 32'(bus.dbg_data);
        end
        S_PC:    obs = 32'(bus.pc);
        S_HALT:  obs = 32'(bus.halted);
        S_SERR:  obs = 32'(bus.stack_err);
        default: obs = 32'(last_cycles);
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // Called just after a falling edge, before the next rising edge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input int base);
    bus.load_en = 1'b1;
    foreach (prog[i]) begin
      bus.load_addr = AW'(base + i);
      bus.load_data = prog[i];
      @(negedge clk);
    end
    bus.load_en = 1'b0;
    prog.delete();
  endtask

  task automatic run(input string name, input int budget);
    last_cycles = 0;
    while (!bus.halted && last_cycles < budget) begin
      @(negedge clk);
      last_cycles++;
    end
    $display("run %s: %0d cycles, pc=%0d halted=%0b stack_err=%0b",
             name, last_cycles, bus.pc, bus.halted, bus.stack_err);
  endtask

  initial begin
    reset = 1'b1;
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.dbg_sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    expect_val("rst_pc", S_PC, 0);
    expect_val("rst_halted", S_HALT, 0);
    expect_val("rst_stack_err", S_SERR, 0);
    for (int r = 0; r < 4; r++) expect_val($sformatf("rst_r%0d", r), r, 0);
    drain();

    // Basic add
    prog = '{ri(O_LDI, 0, 5), ri(O_LDI, 1, 3), rr(O_ADD, 0, 1), jt(O_HALT, 0)};
    load(0);
    expect_val("add_r0", 0, 8); expect_val("add_r1", 1, 3);
    expect_val("add_pc", S_PC, 3); expect_val("add_halted", S_HALT, 1);
    expect_val("add_cycles", S_CYC, 4);
    run("add", 100); drain();

    // Countdown loop
    do_reset();
    prog = '{ri(O_LDI, 0, 3), ri(O_SUBI, 0, 1), jt(O_JNZ, 1), jt(O_HALT, 0)};
    load(0);
    expect_val("loop_r0", 0, 0); expect_val("loop_pc", S_PC, 3);
    expect_val("loop_cycles", S_CYC, 8);
    run("loop", 100); drain();

    // CMP 2 vs 5: JL taken, JG not taken
    do_reset();
    prog = '{ri(O_LDI, 0, 2), ri(O_LDI, 1, 5), rr(O_CMP, 0, 1), jt(O_JL, 5),
             ri(O_LDI, 2, 8'hEE), jt(O_JG, 8), ri(O_LDI, 3, 8'h33), jt(O_HALT, 0)};
    load(0);
    expect_val("jl_r0_kept", 0, 2); expect_val("jl_skip_r2", 2, 0);
    expect_val("jg_fall_r3", 3, 8'h33); expect_val("cmp1_pc", S_PC, 7);
    run("cmp_lt", 100); drain();

    // CMP 5 vs 2: JG taken
    do_reset();
    prog = '{ri(O_LDI, 0, 5), ri(O_LDI, 1, 2), rr(O_CMP, 0, 1), jt(O_JG, 5),
             ri(O_LDI, 2, 8'hEE), ri(O_LDI, 3, 8'h44), jt(O_HALT, 0)};
    load(0);
    expect_val("jg_skip_r2", 2, 0); expect_val("jg_r3", 3, 8'h44);
    expect_val("cmp2_pc", S_PC, 6);
    run("cmp_gt", 100); drain();

    // Carry/zero from ADDI wrap, then logic ops
    do_reset();
    prog = '{ri(O_LDI, 0, 8'hFF), ri(O_ADDI, 0, 1), jt(O_JZ, 4), jt(O_HALT, 0),
             jt(O_JL, 6), jt(O_HALT, 0), ri(O_LDI, 1, 8'h11), rr(O_NOT, 2, 1),
             rr(O_XOR, 2, 1), jt(O_HALT, 0)};
    load(0);
    expect_val("wrap_r0", 0, 0); expect_val("not_xor_r2", 2, 8'hFF);
    expect_val("flags_pc", S_PC, 9);
    run("carry", 100); drain();

    // CALL/RET round trip
    prog = '{jt(O_CALL, 4), ri(O_LDI, 1, 9), jt(O_HALT, 0), jt(O_NOP, 0),
             ri(O_LDI, 0, 7), jt(O_RET, 0)};
    load(0);
    expect_val("call_r0", 0, 7); expect_val("ret_r1", 1, 9);
    expect_val("callret_pc", S_PC, 2); expect_val("callret_serr", S_SERR, 0);
    expect_val("callret_cycles", S_CYC, 5);
    run("callret", 100); drain();

    // Five nested CALLs overflow a 4-deep stack
    prog = '{jt(O_CALL, 1), jt(O_CALL, 2), jt(O_CALL, 3), jt(O_CALL, 4),
             jt(O_CALL, 5), jt(O_HALT, 0)};
    load(0);
    expect_val("ovf_pc", S_PC, 4); expect_val("ovf_halted", S_HALT, 1);
    expect_val("ovf_serr", S_SERR, 1);
    run("call_ovf", 100); drain();

    // RET on empty stack after reset
    do_reset();
    prog = '{jt(O_RET, 0), jt(O_HALT, 0)};
    load(0);
    expect_val("unf_pc", S_PC, 0); expect_val("unf_halted", S_HALT, 1);
    expect_val("unf_serr", S_SERR, 1);
    run("ret_unf", 100); drain();

    // End of program memory: no wrap
    prog = '{jt(O_JMP, 250)};
    load(0);
    for (int i = 0; i < 6; i++) prog.push_back(jt(O_NOP, 0));
    load(250);
    expect_val("end_pc", S_PC, 255); expect_val("end_halted", S_HALT, 1);
    expect_val("end_serr", S_SERR, 0); expect_val("end_cycles", S_CYC, 7);
    run("pc_end", 100); drain();

    // Store/load loop, reset mid-flight, reload and read dmem back
    do_reset();
    prog = '{ri(O_LDI, 1, 4), ri(O_LDI, 0, 8'h5A), rr(O_ST, 0, 1), rr(O_LD, 2, 1),
             ri(O_ADDI, 3, 1), jt(O_JMP, 4)};
    load(0);
    repeat (20) @(negedge clk);
    $display("run st_ld_loop: 20 cycles, pc=%0d", bus.pc);
    expect_val("stld_r2", 2, 8'h5A); expect_val("stld_r1", 1, 4);
    expect_val("loop_running", S_HALT, 0);
    drain();
    do_reset();
    expect_val("mid_rst_pc", S_PC, 0); expect_val("mid_rst_halted", S_HALT, 0);
    for (int r = 0; r < 4; r++) expect_val($sformatf("mid_rst_r%0d", r), r, 0);
    drain();
    prog = '{ri(O_LDI, 1, 4), rr(O_LD, 0, 1), jt(O_HALT, 0)};
    load(0);
    expect_val("dmem_kept_r0", 0, 8'h5A); expect_val("reload_pc", S_PC, 2);
    expect_val("reload_cycles", S_CYC, 3);
    run("reload", 100); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
